// File: rtl/led_framebuffer_pkg.sv
// led_framebuffer_pkg: shared widths, colour field offsets and panel data line order
package led_framebuffer_pkg;
  localparam int N_ROWS_MAX = 64;
  localparam int N_COLS_MAX = 64;
  localparam int BITDEPTH_MAX = 8;
  localparam int CTRL_WIDTH = 32;
  localparam int MEM_DEPTH = N_ROWS_MAX * N_COLS_MAX;
  localparam int WAW = $clog2(MEM_DEPTH);
  localparam int WDW = 3 * BITDEPTH_MAX;
  localparam int RAW = WAW - 1;
  localparam int RDW = 6;
  localparam int BW = $clog2(BITDEPTH_MAX);
  localparam int R_OFF = 2;
  localparam int G_OFF = 1;
  localparam int B_OFF = 0;
  localparam int DOUT_R0 = 5;
  localparam int DOUT_G0 = 4;
  localparam int DOUT_B0 = 3;
  localparam int DOUT_R1 = 2;
  localparam int DOUT_G1 = 1;
  localparam int DOUT_B1 = 0;
  function automatic logic [2:0] plane(input logic [WDW-1:0] px, input logic [BW-1:0] b);
    logic [BITDEPTH_MAX-1:0] r, g, bl;
    r = px[R_OFF*BITDEPTH_MAX +: BITDEPTH_MAX];
    g = px[G_OFF*BITDEPTH_MAX +: BITDEPTH_MAX];
    bl = px[B_OFF*BITDEPTH_MAX +: BITDEPTH_MAX];
    return {r[b], g[b], bl[b]};
  endfunction
endpackage

// File: rtl/led_framebuffer_if.sv
// led_framebuffer_if: pixel upload and scan read signals of the frame store
interface led_framebuffer_if;
  import led_framebuffer_pkg::*;
  logic w_en;
  logic w_buffer;
  logic [WAW-1:0] w_addr;
  logic [WDW-1:0] w_din;
  logic [CTRL_WIDTH-1:0] ctrl_bitdepth;
  logic r_en;
  logic r_buffer;
  logic [RAW-1:0] r_addr;
  logic [BW-1:0] r_bit;
  logic [RDW-1:0] r_dout;
  modport master (
    output w_en, w_buffer, w_addr, w_din, ctrl_bitdepth, r_en, r_buffer, r_addr, r_bit,
    input r_dout
  );
  modport slave (
    input w_en, w_buffer, w_addr, w_din, ctrl_bitdepth, r_en, r_buffer, r_addr, r_bit,
    output r_dout
  );
endinterface

// File: rtl/led_framebuffer_fb_ram_sdp.sv
// fb_ram_sdp: simple dual-port RAM, registered read-first output held when re is low
module fb_ram_sdp #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/led_framebuffer.sv
// led_framebuffer: double-buffered RGB store returning one bit-plane of a top/bottom pixel pair
module led_framebuffer
  import led_framebuffer_pkg::*;
(
  input logic clk,
  input logic rst,
  led_framebuffer_if.slave bus
);
  logic [WDW-1:0] top_q, bot_q;
  logic [BW-1:0] bit_q;
  logic on_q, clr_q;
  logic plane_on;
  logic [2:0] top_p, bot_p;
  logic [RDW-1:0] dout;
  fb_ram_sdp #(.AW(WAW), .DW(WDW)) u_top (
    .clk(clk), .we(bus.w_en & ~bus.w_addr[WAW-1]),
    .waddr({bus.w_buffer, bus.w_addr[RAW-1:0]}), .wdata(bus.w_din),
    .re(bus.r_en), .raddr({bus.r_buffer, bus.r_addr}), .rdata(top_q)
  );
  fb_ram_sdp #(.AW(WAW), .DW(WDW)) u_bot (
    .clk(clk), .we(bus.w_en & bus.w_addr[WAW-1]),
    .waddr({bus.w_buffer, bus.w_addr[RAW-1:0]}), .wdata(bus.w_din),
    .re(bus.r_en), .raddr({bus.r_buffer, bus.r_addr}), .rdata(bot_q)
  );
  assign plane_on = (CTRL_WIDTH'(bus.r_bit) < bus.ctrl_bitdepth) && (int'(bus.r_bit) < BITDEPTH_MAX);
  // RAM output registers cannot be reset, so clr_q blanks r_dout until the next read
  always_ff @(posedge clk) begin
    if (rst) clr_q <= 1'b1;
    else if (bus.r_en) clr_q <= 1'b0;
    if (bus.r_en) begin
      bit_q <= bus.r_bit;
      on_q <= plane_on;
    end
  end
  always_comb begin
    top_p = plane(top_q, bit_q);
    bot_p = plane(bot_q, bit_q);
    dout = '0;
    if (!clr_q && on_q) begin
      dout[DOUT_R0] = top_p[2];
      dout[DOUT_G0] = top_p[1];
      dout[DOUT_B0] = top_p[0];
      dout[DOUT_R1] = bot_p[2];
      dout[DOUT_G1] = bot_p[1];
      dout[DOUT_B1] = bot_p[0];
    end
  end
  assign bus.r_dout = dout;
endmodule

// File: tb/tb_led_framebuffer.sv
// tb_led_framebuffer: directed vector table plus randomized traffic against a pixel-array model
module tb_led_framebuffer;
  typedef struct {
    logic rst, we, wb;
    logic [11:0] wa;
    logic [23:0] wd;
    logic re, rb;
    logic [10:0] ra;
    logic [2:0] rbit;
    logic [31:0] cbd;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  bit [23:0] model [2][4096];
  logic [5:0] model_dout = '0;
  vec_t tbl [$];

  led_framebuffer_if bus();
  led_framebuffer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic we, logic wb, logic [11:0] wa, logic [23:0] wd,
                              logic re, logic rb, logic [10:0] ra, logic [2:0] rbit,
                              logic [31:0] cbd, logic [5:0] exp);
    vec_t v;
    v.rst = r; v.we = we; v.wb = wb; v.wa = wa; v.wd = wd;
    v.re = re; v.rb = rb; v.ra = ra; v.rbit = rbit; v.cbd = cbd; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] ref_read(logic rb, logic [10:0] ra, logic [2:0] b, logic [31:0] cbd);
    int eff, bi;
    bit [23:0] t, u;
    eff = (cbd > 8) ? 8 : int'(cbd);
    bi = int'(b);
    if (bi >= eff) return 6'b0;
    t = model[rb][ra];
    u = model[rb][int'(ra) + 2048];
    return {t[16+bi], t[8+bi], t[bi], u[16+bi], u[8+bi], u[bi]};
  endfunction

  task automatic apply(input vec_t v, input bit use_model, input string name);
    logic [5:0] exp;
    rst = v.rst;
    bus.w_en = v.we; bus.w_buffer = v.wb; bus.w_addr = v.wa; bus.w_din = v.wd;
    bus.r_en = v.re; bus.r_buffer = v.rb; bus.r_addr = v.ra; bus.r_bit = v.rbit;
    bus.ctrl_bitdepth = v.cbd;
    @(posedge clk);
    if (v.rst) model_dout = '0;
    else if (v.re) model_dout = ref_read(v.rb, v.ra, v.rbit, v.cbd);
    if (v.we) model[v.wb][v.wa] = v.wd;
    #1;
    exp = use_model ? model_dout : v.exp;
    vectors++;
    if (bus.r_dout !== exp) begin
      miscompares++;
      $display("FAIL %s: r_dout=%b expected %b", name, bus.r_dout, exp);
    end
  endtask

  initial begin
    vec_t v;
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 6'b000000));
    tbl.push_back(mk(0, 1, 0, 0, 24'hAAFF11, 0, 0, 0, 0, 8, 6'b000000));
    tbl.push_back(mk(0, 1, 0, 2048, 24'hAAFF11, 0, 0, 0, 0, 8, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 6'b011011));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8, 6'b110110));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2, 8, 6'b010010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 3, 8, 6'b110110));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 8, 6'b011011));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 5, 8, 6'b110110));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 6, 8, 6'b010010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 7, 8, 6'b110110));
    tbl.push_back(mk(0, 1, 1, 5, 24'hFF0000, 0, 0, 0, 0, 8, 6'b110110));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5, 3, 8, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 5, 3, 8, 6'b100000));
    tbl.push_back(mk(0, 1, 0, 10, 24'hFFFFFF, 0, 0, 0, 0, 8, 6'b100000));
    tbl.push_back(mk(0, 1, 0, 2058, 24'hFFFFFF, 0, 0, 0, 0, 8, 6'b100000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 10, 3, 4, 6'b111111));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 10, 4, 4, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 10, 7, 9, 6'b111111));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 6'b111111));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 3, 8, 6'b111111));
    tbl.push_back(mk(1, 1, 0, 1, 24'h000001, 0, 0, 0, 0, 8, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 10, 3, 8, 6'b000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 8, 6'b001000));
    tbl.push_back(mk(0, 1, 0, 0, 24'h000000, 1, 0, 0, 0, 8, 6'b011011));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 6'b000011));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 10, 0, 8, 6'b000000));
    foreach (tbl[i]) apply(tbl[i], 1'b0, $sformatf("tbl[%0d]", i));
    for (int i = 0; i < 400; i++) begin
      v.rst = ($urandom_range(0, 31) == 0);
      v.we = $urandom_range(0, 1);
      v.wb = $urandom_range(0, 1);
      v.wa = 12'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 12'd2048 : 12'd0);
      v.wd = 24'($urandom);
      v.re = ($urandom_range(0, 3) != 0);
      v.rb = $urandom_range(0, 1);
      v.ra = 11'($urandom_range(0, 15));
      v.rbit = 3'($urandom_range(0, 7));
      v.cbd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 10)) : 32'd8;
      v.exp = '0;
      apply(v, 1'b1, $sformatf("rand[%0d]", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
